// File: rtl/d7s_pkg.sv
// Shared constants, state encoding and the reverse double-dabble step
// used by the 7-segment bus reader.
package d7s_pkg;

  // Active-high ABCDEFG patterns, bit6 = A ... bit0 = G
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;

  localparam logic [2:0] SEL_UNITS = 3'b110;
  localparam logic [2:0] SEL_TENS  = 3'b101;
  localparam logic [2:0] SEL_HUND  = 3'b011;

  localparam int CONV_STEPS = 8;

  typedef enum logic [1:0] {COLLECT, CONVERT, DONE} state_t;

  // One step on {bcd[11:0], bin[7:0]}: shift right, then pull every
  // BCD nibble that landed at >= 8 back down by 3.
  function automatic logic [19:0] rdd_step(input logic [19:0] w);
    logic [19:0] s;
    s = w >> 1;
    for (int i = 0; i < 3; i++) begin
      if (s[8 + 4*i + 3]) s[8 + 4*i +: 4] = s[8 + 4*i +: 4] - 4'd3;
    end
    return s;
  endfunction

endpackage

// File: rtl/d7s_lector_if.sv
// Display bus (select + segments) and the decoded-result bundle.
interface d7s_lector_if;
  logic [2:0]  transistor;
  logic [6:0]  d7sp;
  logic [7:0]  value;
  logic [11:0] bcd;
  logic        valid;
  logic        seg_err;
  logic        range_err;

  modport master (output transistor, d7sp,
                  input  value, bcd, valid, seg_err, range_err);
  modport slave  (input  transistor, d7sp,
                  output value, bcd, valid, seg_err, range_err);
endinterface

// File: rtl/seg7_decode.sv
// Active-low 7-segment pattern to BCD digit; unknown patterns give 0
// with ok deasserted.
module seg7_decode
  import d7s_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] digit,
  output logic       ok
);

  always_comb begin
    digit = 4'd0;
    ok    = 1'b1;
    case (~seg_n)
      SEG_0: digit = 4'd0;
      SEG_1: digit = 4'd1;
      SEG_2: digit = 4'd2;
      SEG_3: digit = 4'd3;
      SEG_4: digit = 4'd4;
      SEG_5: digit = 4'd5;
      SEG_6: digit = 4'd6;
      SEG_7: digit = 4'd7;
      SEG_8: digit = 4'd8;
      SEG_9: digit = 4'd9;
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/d7s_lector.sv
// Reads a multiplexed 7-segment bus back: debounces select/segment pairs,
// collects a 3-digit frame and converts it to binary.
module d7s_lector
  import d7s_pkg::*;
#(
  parameter int STABLE_CYC = 2
) (
  input  logic         clk,
  input  logic         rst,
  d7s_lector_if.slave  bus
);

  logic [9:0]  in_cur;
  logic [9:0]  in_q_reg;
  logic [4:0]  run_reg;
  logic [4:0]  run_len;
  logic [2:0]  sel_hot;
  logic        accept;
  logic [3:0]  dec_digit;
  logic        dec_ok;
  logic [2:0]  mask_reg, mask_next;
  logic [11:0] dig_reg, dig_next;
  logic        seg_flag_reg;
  logic [19:0] work_reg, work_step;
  logic [2:0]  step_reg;
  logic        frame_done, last_step, over_range;
  logic        is_collect, is_convert;
  state_t      state_reg, state_next;
  logic [7:0]  value_reg;
  logic [11:0] bcd_reg;
  logic        seg_err_reg, range_err_reg;

  assign in_cur  = {bus.transistor, bus.d7sp};
  assign sel_hot = {bus.transistor == SEL_HUND,
                    bus.transistor == SEL_TENS,
                    bus.transistor == SEL_UNITS};

  // Run length includes the current cycle; saturating at 16 keeps a long
  // dwell from matching STABLE_CYC a second time.
  assign run_len = (in_cur == in_q_reg) ? run_reg + 5'd1 : 5'd1;
  assign accept  = is_collect && (run_len == 5'(STABLE_CYC)) && (|sel_hot);

  seg7_decode u_dec (
    .seg_n (bus.d7sp),
    .digit (dec_digit),
    .ok    (dec_ok)
  );

  assign mask_next = accept ? (mask_reg | sel_hot) : mask_reg;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
      assign dig_next[4*gi +: 4] = (accept && sel_hot[gi]) ? dec_digit
                                                            : dig_reg[4*gi +: 4];
    end
  endgenerate

  assign frame_done = is_collect && (mask_next == 3'b111);
  assign last_step  = (step_reg == 3'(CONV_STEPS - 1));
  assign work_step  = rdd_step(work_reg);
  assign over_range = (dig_reg[11:8] > 4'd2) ||
                      ((dig_reg[11:8] == 4'd2) &&
                       ((dig_reg[7:4] > 4'd5) ||
                        ((dig_reg[7:4] == 4'd5) && (dig_reg[3:0] > 4'd5))));

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= COLLECT;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (frame_done) state_next = CONVERT;
      CONVERT: if (last_step)  state_next = DONE;
      DONE:    state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_comb begin
    is_collect = (state_reg == COLLECT);
    is_convert = (state_reg == CONVERT);
    bus.valid  = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_q_reg      <= '0;
      run_reg       <= '0;
      mask_reg      <= '0;
      dig_reg       <= '0;
      seg_flag_reg  <= 1'b0;
      work_reg      <= '0;
      step_reg      <= '0;
      value_reg     <= '0;
      bcd_reg       <= '0;
      seg_err_reg   <= 1'b0;
      range_err_reg <= 1'b0;
    end else begin
      in_q_reg <= in_cur;
      run_reg  <= run_len[4] ? 5'd16 : run_len;
      if (accept) begin
        mask_reg     <= mask_next;
        dig_reg      <= dig_next;
        seg_flag_reg <= seg_flag_reg | ~dec_ok;
      end
      if (frame_done) begin
        work_reg <= {dig_next, 8'd0};
        step_reg <= '0;
      end
      if (is_convert) begin
        work_reg <= work_step;
        step_reg <= step_reg + 3'd1;
        // Results land on the final step so they are stable during DONE
        if (last_step) begin
          bcd_reg       <= dig_reg;
          seg_err_reg   <= seg_flag_reg;
          range_err_reg <= over_range;
          value_reg     <= over_range ? 8'hFF : work_step[7:0];
        end
      end
      if (state_reg == DONE) begin
        mask_reg     <= '0;
        seg_flag_reg <= 1'b0;
      end
    end
  end

  assign bus.value     = value_reg;
  assign bus.bcd       = bcd_reg;
  assign bus.seg_err   = seg_err_reg;
  assign bus.range_err = range_err_reg;

endmodule

// File: tb/tb_d7s_lector.sv
// Directed frames on the display bus; expected results are queued by the
// driver and checked by a monitor whenever valid pulses.
module tb_d7s_lector;

  localparam int STABLE = 2;

  typedef struct {
    logic [7:0]  value;
    logic [11:0] bcd;
    logic        seg;
    logic        rng;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  d7s_lector_if bus ();

  d7s_lector #(.STABLE_CYC(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'b0000001;
      1: s = 7'b1001111;
      2: s = 7'b0010010;
      3: s = 7'b0000110;
      4: s = 7'b1001100;
      5: s = 7'b0100100;
      6: s = 7'b0100000;
      7: s = 7'b0001111;
      8: s = 7'b0000000;
      9: s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  task automatic set_digit(input logic [2:0] sel, input logic [6:0] seg, output int s);
    @(posedge clk);
    #1;
    bus.transistor = sel;
    bus.d7sp       = seg;
    s              = cyc;
  endtask

  task automatic hold(input int n);
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic idle(input int n);
    int s;
    set_digit(3'b111, 7'h7F, s);
    hold(n);
  endtask

  // Units, tens, hundreds, 4 cycles each; valid expected 8 cycles after
  // the hundreds capture edge.
  task automatic frame(input logic [6:0] su, input logic [6:0] st, input logic [6:0] sh,
                       input logic [7:0] ev, input logic [11:0] eb,
                       input logic es, input logic er);
    int s;
    exp_t e;
    set_digit(3'b110, su, s); hold(4);
    set_digit(3'b101, st, s); hold(4);
    set_digit(3'b011, sh, s);
    e.value = ev; e.bcd = eb; e.seg = es; e.rng = er; e.cyc = s + STABLE + 8;
    sb.push_back(e);
    hold(4);
    idle(12);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_value"}, 32'(bus.value), 0);
    chk({tag, "_bcd"}, 32'(bus.bcd), 0);
    chk({tag, "_valid"}, 32'(bus.valid), 0);
    chk({tag, "_seg_err"}, 32'(bus.seg_err), 0);
    chk({tag, "_range_err"}, 32'(bus.range_err), 0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.valid === 1'b1) begin
      $display("valid @%0d: value=%0d bcd=%03h seg_err=%0b range_err=%0b",
               cyc, bus.value, bus.bcd, bus.seg_err, bus.range_err);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got valid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("value", 32'(bus.value), int'(e.value));
        chk("bcd", 32'(bus.bcd), int'(e.bcd));
        chk("seg_err", 32'(bus.seg_err), int'(e.seg));
        chk("range_err", 32'(bus.range_err), int'(e.rng));
        chk("latency", 32'(cyc), e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    bus.transistor = 3'b111;
    bus.d7sp       = 7'h7F;
    rst            = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    idle(4);

    frame(seg_of(7), seg_of(3), seg_of(1), 8'd137, 12'h137, 1'b0, 1'b0);
    frame(seg_of(5), seg_of(5), seg_of(2), 8'd255, 12'h255, 1'b0, 1'b0);
    frame(seg_of(0), seg_of(0), seg_of(0), 8'd0,   12'h000, 1'b0, 1'b0);
    frame(seg_of(6), seg_of(5), seg_of(2), 8'hFF,  12'h256, 1'b0, 1'b1);
    frame(seg_of(9), seg_of(9), seg_of(9), 8'hFF,  12'h999, 1'b0, 1'b1);
    frame(seg_of(4), 7'b1111111, seg_of(1), 8'd104, 12'h104, 1'b1, 1'b0);

    // Illegal selects and a 1-cycle legal glitch must not capture anything
    set_digit(3'b000, seg_of(9), s); hold(20);
    set_digit(3'b111, seg_of(9), s); hold(20);
    set_digit(3'b110, seg_of(9), s); hold(1);
    idle(10);
    set_digit(3'b101, seg_of(4), s); hold(4);
    set_digit(3'b011, seg_of(1), s); hold(4);
    idle(15);
    begin
      exp_t e;
      set_digit(3'b110, seg_of(7), s);
      e.value = 8'd147; e.bcd = 12'h147; e.seg = 1'b0; e.rng = 1'b0;
      e.cyc = s + STABLE + 8;
      sb.push_back(e);
      hold(4);
      idle(12);
    end

    // Reset during the 4th CONVERT cycle aborts the frame
    set_digit(3'b110, seg_of(5), s); hold(4);
    set_digit(3'b101, seg_of(5), s); hold(4);
    set_digit(3'b011, seg_of(5), s);
    repeat (5) @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.transistor = 3'b111;
    bus.d7sp       = 7'h7F;
    @(posedge clk);
    #1;
    chk_zero("abort");
    rst = 1'b1;
    idle(15);

    frame(seg_of(2), seg_of(4), seg_of(0), 8'd42, 12'h042, 1'b0, 1'b0);

    idle(20);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/d7s_lector.md
Name: d7s_lector

Overview:
- Receive-side counterpart of the multiplexed 7-segment display driver.
- Samples the time-multiplexed digit-select / segment bus, decodes each segment pattern back to a BCD digit and collects one full frame (units, tens, hundreds).
- Converts the frame to an 8-bit binary value by sequential reverse double-dabble.
- Used for display loop-back self-test and for reading the display bus back on the bench.

Parameters:
- STABLE_CYC, 2: consecutive identical cycles required before a (select, segment) pair is accepted; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- transistor  in  3  digit select, active-low: 110 = units, 101 = tens, 011 = hundreds; any other code is idle/invalid
- d7sp  in  7  segments, active-low, bit6 = A … bit0 = G
- value  out  8  converted binary value, held until next frame
- bcd  out  12  {hundreds, tens, units} digits of the last frame, held
- valid  out  1  one-cycle pulse when value/bcd/error flags update
- seg_err  out  1  last frame contained an undecodable segment pattern; held
- range_err  out  1  last frame exceeded 255; held

Behaviour:
- Reset (rst=0 at posedge):
  - value, bcd, valid, seg_err and range_err all go to 0.
  - Collect mask, stability counter and input copy clear.
  - State goes to COLLECT.
  - Reset overrides everything, including a conversion in progress.
- Input stabilisation:
  - in_q is a one-cycle registered copy of {transistor, d7sp}.
  - The run counter restarts when the input differs from in_q.
  - A pair is accepted in the cycle where the same pair has been present for STABLE_CYC consecutive cycles, including the current one.
  - Acceptance happens only if transistor is a legal select code.
  - At most one acceptance per dwell; re-arm only after the input changes.
- Segment decode, combinational on ~d7sp:
  - Standard ABCDEFG codes for 0..9; 7 uses A, B, C only.
  - Any other pattern, including blank, decodes as digit 0 and sets the per-frame seg flag.
- State COLLECT:
  - An accepted pair writes its digit to the slot chosen by transistor and sets that mask bit.
  - A later acceptance for the same slot overwrites the digit.
  - When the mask becomes 111, latch the frame and go to CONVERT on the next cycle.
- State CONVERT, exactly 8 cycles:
  - Working register {bcd_w[11:0], bin_w[7:0]}.
  - Each cycle: shift right by 1, then subtract 3 from every bcd_w nibble that is >= 8.
  - Inputs are ignored in CONVERT and DONE.
- State DONE, 1 cycle:
  - Register bcd = latched digits and assert valid=1.
  - seg_err = frame seg flag.
  - range_err = 1 if the frame is > 255; compare decimally: h>2, or h=2 and (t>5, or t=5 and u>5).
  - value = 8'hFF when range_err, else bin_w.
  - Clear the mask and frame seg flag, then return to COLLECT.
- Latency: valid is high in the 9th cycle after the cycle that captures the last missing digit.
- Dwell length: a dwell shorter than STABLE_CYC cycles is never captured.
- Back-to-back frames: the digits seen during CONVERT/DONE are lost. The next frame needs three fresh acceptances.

Decomposition:
- Package d7s_pkg:
  - Segment constants SEG_0..SEG_9 (active-high ABCDEFG).
  - Select codes SEL_UNITS=3'b110, SEL_TENS=3'b101, SEL_HUND=3'b011.
  - State enum {COLLECT, CONVERT, DONE}.
  - CONV_STEPS=8.
- Sub-module seg7_decode: combinational, takes 7-bit active-low segments and returns a 4-bit digit plus an ok flag. Instanced once, on d7sp.

Test Plan:
- Drive 137, each digit dwelling 4 cycles (sequence 110/101/011) -> valid pulse with value=137, bcd=12'h137, seg_err=0, range_err=0, exactly 9 cycles after the hundreds capture.
- Drive 255 -> value=8'hFF, range_err=0. Then drive 0 (all digits ~7'b1111110) -> value=0, bcd=0.
- Drive 256 -> range_err=1, value=8'hFF, bcd=12'h256. Drive 999 -> range_err=1, value=8'hFF.
- Tens segment = 7'b1111111 (blank), units=4, hundreds=1 -> seg_err=1, bcd=12'h104, value=104.
- Select 000 or 111 held for 20 cycles, plus a 1-cycle legal glitch with STABLE_CYC=2 -> no capture, no valid.
- Assert rst=0 in the 4th CONVERT cycle -> all outputs 0 at the next edge, no valid. After release, a full 42 frame -> value=42.
